// File: rtl/pciexp_sym_pkg.sv
// Symbol codes and scheduler state encoding shared by the PCIEXP TX scheduler,
// RX decoder and ordered-set detector.
package pciexp_sym_pkg;

  localparam logic [7:0] K28_5_COM = 8'hBC;
  localparam logic [7:0] K28_0_SKP = 8'h1C;
  localparam logic [7:0] D0_0_IDL  = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    SKP  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/pciexp_skp_timer.sv
// Free-running SKP interval timer with a single-deep pending flag.
module pciexp_skp_timer #(
  parameter int SKP_INTERVAL = 1180
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic ack_i,
  output logic pend_o
);

  logic [11:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        expire;

  assign expire = (cnt_q == 12'(SKP_INTERVAL - 1));

  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (clear_i) begin
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (expire) begin
      // a fresh expiry wins over a same-cycle ack so the request is never lost
      cnt_d  = '0;
      pend_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 12'd1;
      if (ack_i) pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/pciexp_tx_sym_sched.sv
// TX symbol scheduler: picks packet data, SKP ordered sets or logical idle per
// symbol clock and drives the 8b10b encoder's reset/disparity controls.
module pciexp_tx_sym_sched
  import pciexp_sym_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_LEN      = 3
) (
  input  logic       PCLK250,
  input  logic       Reset_P2,
  input  logic       TxEnable_P2,
  input  logic       TxValid_P2,
  input  logic [7:0] TxData_P2,
  input  logic       TxK_P2,
  input  logic       TxSop_P2,
  input  logic       TxEop_P2,
  output logic       TxReady_P2,
  output logic [7:0] EncData_P2,
  output logic       EncKCode_P2,
  output logic       EncUseNegDisp_P2,
  output logic       EncReset_P2,
  output logic       SkpSent_P2,
  output logic       TxUnderrun_P2
);

  sched_state_e state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [7:0]   data_q, data_d;
  logic         k_q, k_d;
  logic         neg_q, neg_d;
  logic         skp_q, skp_d;
  logic         und_q, und_d;
  logic         enc_rst_q, rst_dly_q, en_q;
  logic         en_eff, ready, skp_pend, skp_ack;

  // The cycle right after reset is held off so nothing is accepted while the
  // encoder is still in reset.
  assign en_eff = TxEnable_P2 & ~Reset_P2 & ~rst_dly_q;

  pciexp_skp_timer #(
    .SKP_INTERVAL(SKP_INTERVAL)
  ) u_skp_timer (
    .clk_i  (PCLK250),
    .rst_i  (Reset_P2),
    .clear_i(~en_eff),
    .ack_i  (skp_ack),
    .pend_o (skp_pend)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = D0_0_IDL;
    k_d     = 1'b0;
    skp_d   = 1'b0;
    und_d   = 1'b0;
    ready   = 1'b0;
    skp_ack = 1'b0;
    if (!en_eff) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (skp_pend) begin
            data_d  = K28_5_COM;
            k_d     = 1'b1;
            skp_d   = 1'b1;
            skp_ack = 1'b1;
            idx_d   = '0;
            state_d = SKP;
          end else begin
            ready = 1'b1;
            if (TxValid_P2 && TxSop_P2) begin
              data_d = TxData_P2;
              k_d    = TxK_P2;
              if (!TxEop_P2) state_d = PKT;
            end
          end
        end
        PKT: begin
          ready = 1'b1;
          if (TxValid_P2) begin
            data_d = TxData_P2;
            k_d    = TxK_P2;
            if (TxEop_P2) state_d = IDLE;
          end else begin
            und_d = 1'b1;
          end
        end
        SKP: begin
          data_d = K28_0_SKP;
          k_d    = 1'b1;
          if (idx_q == 3'(SKP_LEN - 1)) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Force negative disparity on the first symbol after encoder reset releases
  // and on the first symbol after scheduling is (re)enabled.
  assign neg_d = (en_eff & ~en_q) | (enc_rst_q & ~rst_dly_q);

  always_ff @(posedge PCLK250) begin
    if (Reset_P2) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      data_q    <= D0_0_IDL;
      k_q       <= 1'b0;
      neg_q     <= 1'b0;
      skp_q     <= 1'b0;
      und_q     <= 1'b0;
      enc_rst_q <= 1'b1;
      rst_dly_q <= 1'b1;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      k_q       <= k_d;
      neg_q     <= neg_d;
      skp_q     <= skp_d;
      und_q     <= und_d;
      enc_rst_q <= rst_dly_q;
      rst_dly_q <= 1'b0;
      en_q      <= en_eff;
    end
  end

  assign TxReady_P2       = ready;
  assign EncData_P2       = data_q;
  assign EncKCode_P2      = k_q;
  assign EncUseNegDisp_P2 = neg_q;
  assign EncReset_P2      = enc_rst_q;
  assign SkpSent_P2       = skp_q;
  assign TxUnderrun_P2    = und_q;

endmodule

// File: tb/tb_pciexp_tx_sym_sched.sv
// Scoreboard bench for pciexp_tx_sym_sched with a short SKP interval.
module tb_pciexp_tx_sym_sched;

  localparam int INTERVAL = 16;
  localparam int SLEN     = 3;
  localparam int M_IDLE = 0, M_PKT = 1, M_SKP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1, en = 1'b0, valid = 1'b0, tk = 1'b0, sop = 1'b0, eop = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic       ready, ek, eneg, erst, skp_sent, underrun;
  logic [7:0] edata;

  int n_chk = 0;
  int n_err = 0;

  pciexp_tx_sym_sched #(.SKP_INTERVAL(INTERVAL), .SKP_LEN(SLEN)) dut (
    .PCLK250         (clk),
    .Reset_P2        (rst),
    .TxEnable_P2     (en),
    .TxValid_P2      (valid),
    .TxData_P2       (tdata),
    .TxK_P2          (tk),
    .TxSop_P2        (sop),
    .TxEop_P2        (eop),
    .TxReady_P2      (ready),
    .EncData_P2      (edata),
    .EncKCode_P2     (ek),
    .EncUseNegDisp_P2(eneg),
    .EncReset_P2     (erst),
    .SkpSent_P2      (skp_sent),
    .TxUnderrun_P2   (underrun)
  );

  always #2 clk = ~clk;

  // reference model state
  int   m_state = M_IDLE, m_cnt = 0, m_left = 0;
  bit   m_pend = 0, m_blk = 1, m_last_rst = 1, m_en_prev = 0;
  logic [12:0] exp_q[$];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One symbol: drive inputs, predict, then compare the registered result.
  task automatic cyc(input logic i_en, input logic i_v, input logic i_sop, input logic i_eop,
                     input logic i_k, input logic [7:0] i_d, input logic i_rst);
    bit eff, com, e_rst, e_neg, e_k, e_skp, e_und, e_ready;
    logic [7:0] e_data;
    logic [12:0] got;
    en = i_en; valid = i_v; sop = i_sop; eop = i_eop; tk = i_k; tdata = i_d; rst = i_rst;
    #1;
    eff     = i_en && !i_rst && !m_blk;
    e_ready = eff && (m_state == M_PKT || (m_state == M_IDLE && !m_pend));
    chk("ready", {15'd0, ready}, {15'd0, e_ready});
    e_data = 8'h00; e_k = 0; e_skp = 0; e_und = 0; com = 0;
    if (!eff) begin
      m_state = M_IDLE;
    end else begin
      case (m_state)
        M_IDLE:
          if (m_pend) begin
            e_data = 8'hBC; e_k = 1; e_skp = 1; com = 1; m_state = M_SKP; m_left = SLEN;
          end else if (i_v && i_sop) begin
            e_data = i_d; e_k = i_k;
            if (!i_eop) m_state = M_PKT;
          end
        M_PKT:
          if (i_v) begin
            e_data = i_d; e_k = i_k;
            if (i_eop) m_state = M_IDLE;
          end else e_und = 1;
        default: begin
          e_data = 8'h1C; e_k = 1; m_left--;
          if (m_left == 0) m_state = M_IDLE;
        end
      endcase
    end
    if (!eff) begin
      m_cnt = 0; m_pend = 0;
    end else if (m_cnt == INTERVAL - 1) begin
      m_cnt = 0; m_pend = 1;
    end else begin
      m_cnt++;
      if (com) m_pend = 0;
    end
    e_rst = i_rst || m_blk;
    e_neg = !e_rst && ((eff && !m_en_prev) || m_last_rst);
    m_last_rst = e_rst; m_en_prev = eff; m_blk = i_rst;
    exp_q.push_back({e_rst, e_neg, e_skp, e_und, e_k, e_data});
    @(posedge clk); #1;
    got = {erst, eneg, skp_sent, underrun, ek, edata};
    chk("sym", {3'd0, got}, {3'd0, exp_q.pop_front()});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 8'h00, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int skp_n, rdy_lo, und_n, n;
    bit found;
    @(negedge clk);
    // 1: reset and release
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 8'h00, 1);
    chk("rst_data", {8'd0, edata}, 16'h0000);
    cyc(1, 0, 0, 0, 0, 8'h00, 0);
    chk("encrst_hold", {15'd0, erst}, 16'd1);
    cyc(1, 0, 0, 0, 0, 8'h00, 0);
    chk("negdisp_first", {15'd0, eneg}, 16'd1);
    cyc(1, 0, 0, 0, 0, 8'h00, 0);
    chk("negdisp_once", {15'd0, eneg}, 16'd0);

    // 2: idle SKP cadence
    skp_n = 0; rdy_lo = 0;
    for (int i = 0; i < 51; i++) begin
      if (!ready) rdy_lo++;
      cyc(1, 0, 0, 0, 0, 8'h00, 0);
      if (skp_sent) skp_n++;
    end
    chk("skp_sets", 16'(skp_n), 16'd3);
    chk("ready_low", 16'(rdy_lo), 16'd12);

    // 3: 20-byte packet straddling an expiry; COM right after Eop
    for (int i = 0; i < 20; i++)
      cyc(1, 1, i == 0, i == 19, 0, 8'(8'h40 + i), 0);
    chk("eop_byte", {8'd0, edata}, 16'h0053);
    cyc(1, 0, 0, 0, 0, 8'h00, 0);
    chk("com_after_eop", {7'd0, ek, edata}, 16'h01BC);
    idle(3);

    // 4: two-cycle gap mid-packet
    und_n = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3 || i == 4) cyc(1, 0, 0, 0, 0, 8'h00, 0);
      else cyc(1, 1, i == 0, i == 7, 0, 8'(8'h80 + i), 0);
      if (underrun) und_n++;
    end
    chk("underruns", 16'(und_n), 16'd2);
    idle(6);

    // 5: stray non-Sop byte dropped, single-byte packet passes
    cyc(0, 0, 0, 0, 0, 8'h00, 0);
    cyc(1, 1, 0, 0, 0, 8'h77, 0);
    chk("drop_nonsop", {7'd0, ek, edata}, 16'h0000);
    cyc(1, 1, 1, 1, 1, 8'hA5, 0);
    chk("single_byte", {7'd0, ek, edata}, 16'h01A5);
    cyc(1, 1, 0, 0, 0, 8'h66, 0);
    chk("back_idle", {8'd0, edata}, 16'h0000);

    // 6: drop enable mid-SKP and re-raise
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(1, 0, 0, 0, 0, 8'h00, 0);
      found = skp_sent;
    end
    chk("skp_seen", {15'd0, found}, 16'd1);
    cyc(1, 0, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0, 0, 8'h11, 0);
      chk("disabled_idle", {7'd0, ek, edata}, 16'h0000);
    end
    found = 0; n = 99;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(1, 0, 0, 0, 0, 8'h00, 0);
      if (i == 0) chk("negdisp_reen", {15'd0, eneg}, 16'd1);
      if (skp_sent) begin found = 1; n = i; end
    end
    chk("com_delay", 16'(n), 16'(INTERVAL));
    idle(3);

    // reset during a packet
    cyc(1, 1, 1, 0, 0, 8'h31, 0);
    cyc(1, 1, 0, 0, 0, 8'h32, 0);
    cyc(1, 1, 0, 0, 0, 8'h33, 1);
    chk("midrst", {6'd0, erst, ek, edata}, 16'h0200);
    cyc(1, 1, 0, 1, 0, 8'h34, 0);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
